// File: rtl/nonce_search_ctrl.sv
// Nonce search controller: feeds {header, nonce} blocks to the hash core one at a time,
// compares each result against the difficulty target and reports the first winner.
module nonce_search_ctrl #(
    parameter int HASH_W    = 24,
    parameter int MAX_TRIES = 256,
    parameter int CNT_W     = 9,
    parameter int TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [95:0]       data_entry_12,
    input  logic [31:0]       data_nonce,
    input  logic [7:0]        data_target,
    output logic [127:0]      block_out,
    output logic              block_valid,
    input  logic              hash_done,
    input  logic [HASH_W-1:0] hash_in,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic              timeout_err,
    output logic [31:0]       nonce_out,
    output logic [HASH_W-1:0] hash_out,
    output logic [CNT_W-1:0]  attempts
);

    localparam int WAIT_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_END
    } state_t;

    state_t state_q, state_d;

    logic [95:0]       hdr_q;
    logic [31:0]       nonce_q;
    logic [7:0]        target_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [HASH_W-1:0] hash_reg;

    logic pass;
    logic last_try;
    logic wait_expired;

    // Difficulty test looks only at the top byte of the hash.
    assign pass         = hash_reg[HASH_W-1 -: 8] < target_q;
    assign last_try     = (attempts + CNT_W'(1)) == CNT_W'(MAX_TRIES);
    assign wait_expired = wait_cnt == WAIT_W'(TIMEOUT - 1);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                busy    = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                // A result arriving on the last allowed cycle still counts.
                if (hash_done)         state_d = S_CHECK;
                else if (wait_expired) state_d = S_END;
            end
            S_CHECK: begin
                busy    = 1'b1;
                state_d = (pass || last_try) ? S_END : S_ISSUE;
            end
            S_END: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdr_q       <= '0;
            nonce_q     <= '0;
            target_q    <= '0;
            wait_cnt    <= '0;
            hash_reg    <= '0;
            block_out   <= '0;
            block_valid <= 1'b0;
            found       <= 1'b0;
            timeout_err <= 1'b0;
            nonce_out   <= '0;
            hash_out    <= '0;
            attempts    <= '0;
        end else begin
            block_valid <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        hdr_q       <= data_entry_12;
                        nonce_q     <= data_nonce;
                        target_q    <= data_target;
                        found       <= 1'b0;
                        timeout_err <= 1'b0;
                        attempts    <= '0;
                    end
                end
                S_ISSUE: begin
                    block_out   <= {hdr_q, nonce_q};
                    block_valid <= 1'b1;
                    wait_cnt    <= '0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                    if (hash_done)         hash_reg    <= hash_in;
                    else if (wait_expired) timeout_err <= 1'b1;
                end
                S_CHECK: begin
                    attempts <= attempts + CNT_W'(1);
                    if (pass) begin
                        found     <= 1'b1;
                        nonce_out <= nonce_q;
                        hash_out  <= hash_reg;
                    end else if (!last_try) begin
                        nonce_q <= nonce_q + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Self-checking bench for nonce_search_ctrl: directed and randomized searches checked
// against an outcome model derived from the search rules.
module tb_nonce_search_ctrl;

    localparam int HASH_W    = 24;
    localparam int MAX_TRIES = 4;
    localparam int CNT_W     = 9;
    localparam int TIMEOUT   = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [95:0]       data_entry_12;
    logic [31:0]       data_nonce;
    logic [7:0]        data_target;
    logic [127:0]      block_out;
    logic              block_valid;
    logic              hash_done;
    logic [HASH_W-1:0] hash_in;
    logic              busy;
    logic              done;
    logic              found;
    logic              timeout_err;
    logic [31:0]       nonce_out;
    logic [HASH_W-1:0] hash_out;
    logic [CNT_W-1:0]  attempts;

    nonce_search_ctrl #(
        .HASH_W   (HASH_W),
        .MAX_TRIES(MAX_TRIES),
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .data_entry_12(data_entry_12),
        .data_nonce   (data_nonce),
        .data_target  (data_target),
        .block_out    (block_out),
        .block_valid  (block_valid),
        .hash_done    (hash_done),
        .hash_in      (hash_in),
        .busy         (busy),
        .done         (done),
        .found        (found),
        .timeout_err  (timeout_err),
        .nonce_out    (nonce_out),
        .hash_out     (hash_out),
        .attempts     (attempts)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Hash results the model core will return, in order; running out means the core goes silent.
    logic [HASH_W-1:0] resp_q[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_block_out"}, block_out, 128'd0);
        check({tag, "_strobes"}, 128'({block_valid, busy, done, found, timeout_err}), 128'd0);
        check({tag, "_nonce_out"}, 128'(nonce_out), 128'd0);
        check({tag, "_hash_out"}, 128'(hash_out), 128'd0);
        check({tag, "_attempts"}, 128'(attempts), 128'd0);
    endtask

    task automatic run_search(input string tag, input logic [95:0] hdr, input logic [31:0] n0,
                              input logic [7:0] tgt, input bit poke_start, input bit max_delay);
        bit                exp_found = 1'b0;
        bit                exp_to    = 1'b0;
        int                exp_att   = 0;
        int                exp_blocks;
        logic [31:0]       exp_nonce = '0;
        logic [HASH_W-1:0] exp_hash  = '0;
        int                blocks = 0;
        int                ri     = 0;
        int                cyc;
        int                d;
        bit                fin = 1'b0;

        // Outcome model: walk the responses in order, stop at the first pass, at MAX_TRIES,
        // or at the first missing response.
        for (int i = 0; i < MAX_TRIES; i++) begin
            if (i >= resp_q.size()) begin
                exp_to = 1'b1;
                break;
            end
            exp_att = i + 1;
            if (resp_q[i][HASH_W-1 -: 8] < tgt) begin
                exp_found = 1'b1;
                exp_nonce = n0 + 32'(i);
                exp_hash  = resp_q[i];
                break;
            end
        end
        exp_blocks = exp_to ? exp_att + 1 : exp_att;

        data_entry_12 = hdr;
        data_nonce    = n0;
        data_target   = tgt;
        start         = 1'b1;
        @(negedge clk);
        start         = 1'b0;
        data_entry_12 = {$urandom, $urandom, $urandom};
        data_nonce    = $urandom;

        while (!fin) begin
            cyc = 0;
            while (!(block_valid === 1'b1 || done === 1'b1) && cyc < TIMEOUT + 8) begin
                @(negedge clk);
                cyc++;
            end
            if (!(block_valid === 1'b1 || done === 1'b1)) begin
                check({tag, "_event_wait"}, 128'd0, 128'd1);
                fin = 1'b1;
            end else if (done === 1'b1) begin
                fin = 1'b1;
            end else begin
                check({tag, "_blk_latency"}, 128'(1 + cyc), (blocks == 0) ? 128'd2 : 128'd3);
                check({tag, "_block_out"}, block_out, {hdr, n0 + 32'(blocks)});
                check({tag, "_busy"}, 128'(busy), 128'd1);
                blocks++;
                if (ri < resp_q.size()) begin
                    d = max_delay ? TIMEOUT - 1 : $urandom_range(0, TIMEOUT - 1);
                    if (poke_start) start = 1'b1;
                    repeat (d) @(negedge clk);
                    start     = 1'b0;
                    hash_done = 1'b1;
                    hash_in   = resp_q[ri];
                    ri++;
                    @(negedge clk);
                    hash_done = 1'b0;
                    hash_in   = HASH_W'($urandom);
                end else begin
                    cyc = 0;
                    while (done !== 1'b1 && cyc < TIMEOUT + 8) begin
                        @(negedge clk);
                        cyc++;
                    end
                    check({tag, "_timeout_latency"}, 128'(cyc), 128'(TIMEOUT));
                    fin = 1'b1;
                end
            end
        end

        check({tag, "_done"}, 128'(done), 128'd1);
        check({tag, "_busy_end"}, 128'(busy), 128'd0);
        check({tag, "_found"}, 128'(found), 128'(exp_found));
        check({tag, "_timeout_err"}, 128'(timeout_err), 128'(exp_to));
        check({tag, "_attempts"}, 128'(attempts), 128'(exp_att));
        check({tag, "_blocks"}, 128'(blocks), 128'(exp_blocks));
        if (exp_found) begin
            check({tag, "_nonce_out"}, 128'(nonce_out), 128'(exp_nonce));
            check({tag, "_hash_out"}, 128'(hash_out), 128'(exp_hash));
        end
        @(negedge clk);
        check({tag, "_done_once"}, 128'(done), 128'd0);
        check({tag, "_idle_busy"}, 128'(busy), 128'd0);
        check({tag, "_found_hold"}, 128'(found), 128'(exp_found));
    endtask

    initial begin
        logic [HASH_W-1:0] t1_hash;
        int                cyc;
        int                len;

        reset         = 1'b1;
        start         = 1'b0;
        hash_done     = 1'b0;
        hash_in       = '0;
        data_entry_12 = '0;
        data_nonce    = '0;
        data_target   = '0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 1: single block that passes immediately.
        t1_hash = {8'h10, 16'($urandom)};
        resp_q = {t1_hash};
        run_search("t1", 96'h24331f6b6c9eca402f9f7d39, 32'h3c87edfd, 8'hff, 1'b0, 1'b0);

        // 6b: hash_done while idle must not disturb held results.
        hash_done = 1'b1;
        hash_in   = '0;
        repeat (2) @(negedge clk);
        hash_done = 1'b0;
        check("idle_hd_found", 128'(found), 128'd1);
        check("idle_hd_nonce", 128'(nonce_out), 128'h3c87edfd);
        check("idle_hd_hash", 128'(hash_out), 128'(t1_hash));
        check("idle_hd_attempts", 128'(attempts), 128'd1);
        check("idle_hd_busy", 128'({busy, block_valid, done}), 128'd0);

        // 2: third block passes; results arrive on the last allowed wait cycle.
        resp_q = {{8'h80, 16'($urandom)}, {8'h40, 16'($urandom)}, {8'h1f, 16'($urandom)}};
        run_search("t2", {$urandom, $urandom, $urandom}, $urandom, 8'h20, 1'b0, 1'b1);

        // 3: target 0 never passes; nonce wraps past ffffffff; start poked while busy.
        resp_q = {};
        for (int i = 0; i < MAX_TRIES; i++) resp_q.push_back(HASH_W'($urandom));
        run_search("t3", {$urandom, $urandom, $urandom}, 32'hfffffffe, 8'h00, 1'b1, 1'b0);

        // 4: core never answers.
        resp_q = {};
        run_search("t4", {$urandom, $urandom, $urandom}, $urandom, 8'h80, 1'b0, 1'b0);

        // 5: asynchronous reset during the second WAIT.
        data_entry_12 = {$urandom, $urandom, $urandom};
        data_nonce    = $urandom;
        data_target   = 8'h10;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (block_valid !== 1'b1 && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        check("t5_first_block", 128'(block_valid), 128'd1);
        hash_done = 1'b1;
        hash_in   = 24'hff0000;
        @(negedge clk);
        hash_done = 1'b0;
        cyc = 0;
        while (block_valid !== 1'b1 && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        check("t5_second_block", 128'(block_valid), 128'd1);
        check("t5_attempts_pre", 128'(attempts), 128'd1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_all_zero("t5_async");
        @(negedge clk);
        reset     = 1'b0;
        hash_done = 1'b1;
        hash_in   = 24'h000000;
        @(negedge clk);
        hash_done = 1'b0;
        @(negedge clk);
        check_all_zero("t5_after");
        resp_q = {{8'h05, 16'($urandom)}};
        run_search("t5_clean", {$urandom, $urandom, $urandom}, $urandom, 8'h06, 1'b0, 1'b0);

        // Randomized searches.
        for (int k = 0; k < 8; k++) begin
            resp_q = {};
            len = $urandom_range(0, MAX_TRIES + 1);
            for (int i = 0; i < len; i++) resp_q.push_back(HASH_W'($urandom));
            run_search($sformatf("rnd%0d", k), {$urandom, $urandom, $urandom}, $urandom,
                       8'($urandom), k[0], k == 5);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
